// File: rtl/vector_alu_kernel.sv
// Purpose: per-lane add/sub ALU with wrapping or saturating modes, carry/borrow flag per lane.
// Latency: two registered stages; a vector presented before edge N is on out_data after edge N+1 (two edges).
// Backpressure: both stages advance only when the output slot is empty or drained; in_ready follows that.
module vector_alu_kernel #(
    parameter int LANES = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_ovf,
    output logic [15:0]            vec_count
);

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SADD = 2'b10;

    // Stage 1 operand registers
    logic                   s1_vld_q;
    logic [LANES*WIDTH-1:0] s1_a_q;
    logic [LANES*WIDTH-1:0] s1_b_q;
    logic [1:0]             s1_op_q;

    // Stage 2 result registers
    logic                   out_vld_q;
    logic [LANES*WIDTH-1:0] res_q;
    logic [LANES*WIDTH-1:0] res_d;
    logic [LANES-1:0]       ovf_q;
    logic [LANES-1:0]       ovf_d;
    logic [15:0]            cnt_q;
    logic [15:0]            cnt_d;

    // Per-lane scratch for the arithmetic loop
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic [WIDTH:0]   sum_l;
    logic [WIDTH:0]   dif_l;

    logic advance;

    // The whole pipe moves as one; a held output freezes both stages.
    assign advance  = !out_vld_q || out_ready;
    assign in_ready = advance && !rst;

    // Stage 1: capture operands and op together with the accept strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_op_q  <= OP_ADD;
        end else if (advance) begin
            s1_vld_q <= in_valid && in_ready;
            s1_a_q   <= in_a;
            s1_b_q   <= in_b;
            s1_op_q  <= in_op;
        end
    end

    // Lane arithmetic: one extra bit per lane exposes carry (add) or borrow (sub)
    always_comb begin
        res_d = '0;
        ovf_d = '0;
        a_l   = '0;
        b_l   = '0;
        sum_l = '0;
        dif_l = '0;
        for (int i = 0; i < LANES; i++) begin
            a_l   = s1_a_q[i*WIDTH +: WIDTH];
            b_l   = s1_b_q[i*WIDTH +: WIDTH];
            sum_l = {1'b0, a_l} + {1'b0, b_l};
            dif_l = {1'b0, a_l} - {1'b0, b_l};
            case (s1_op_q)
                OP_ADD: begin
                    res_d[i*WIDTH +: WIDTH] = sum_l[WIDTH-1:0];
                    ovf_d[i]                = sum_l[WIDTH];
                end
                OP_SUB: begin
                    res_d[i*WIDTH +: WIDTH] = dif_l[WIDTH-1:0];
                    ovf_d[i]                = dif_l[WIDTH];
                end
                OP_SADD: begin
                    res_d[i*WIDTH +: WIDTH] = sum_l[WIDTH] ? {WIDTH{1'b1}} : sum_l[WIDTH-1:0];
                    ovf_d[i]                = sum_l[WIDTH];
                end
                default: begin
                    res_d[i*WIDTH +: WIDTH] = dif_l[WIDTH] ? {WIDTH{1'b0}} : dif_l[WIDTH-1:0];
                    ovf_d[i]                = dif_l[WIDTH];
                end
            endcase
        end
    end

    // Stage 2: result only overwritten by a real vector so bubbles keep the last value visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            res_q     <= '0;
            ovf_q     <= '0;
        end else if (advance) begin
            out_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                res_q <= res_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign cnt_d = cnt_q + 16'd1;

    // Count completed output handshakes; wraps naturally at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (out_vld_q && out_ready) begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;
    assign vec_count = cnt_q;

endmodule

// File: tb/tb_vector_alu_kernel.sv
// Purpose: randomized and directed checks of vector_alu_kernel against a lane-arithmetic model.
// Latency: expects results two edges after presentation, in order.
// Backpressure: drives random out_ready and checks stalls hold data and block input.
module tb_vector_alu_kernel;

    logic        clk;
    logic        rst;

    // 8 lanes x 8 bits
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_ovf;
    logic [15:0] vec_count;

    // 4 lanes x 16 bits
    logic        in_valid2;
    logic        in_ready2;
    logic [63:0] in_a2;
    logic [63:0] in_b2;
    logic [1:0]  in_op2;
    logic        out_valid2;
    logic        out_ready2;
    logic [63:0] out_data2;
    logic [3:0]  out_ovf2;
    logic [15:0] vec_count2;

    int n_chk;
    int n_fail;

    // Expected results in arrival order, plus expected transfer count
    logic [63:0] exp_dat_q[$];
    logic [63:0] exp_ovf_q[$];
    int          exp_cnt;

    vector_alu_kernel #(.LANES(8), .WIDTH(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .vec_count (vec_count)
    );

    vector_alu_kernel #(.LANES(4), .WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_a      (in_a2),
        .in_b      (in_b2),
        .in_op     (in_op2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_data  (out_data2),
        .out_ovf   (out_ovf2),
        .vec_count (vec_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Plain unsigned arithmetic per lane, straight from the operation definitions
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                         input int n, input int w,
                         output logic [63:0] d, output logic [63:0] f);
        longint unsigned modv;
        longint unsigned av;
        longint unsigned bv;
        longint unsigned r;
        logic            fl;
        modv = 64'd1 << w;
        d = '0;
        f = '0;
        for (int i = 0; i < n; i++) begin
            av = (a >> (i*w)) % modv;
            bv = (b >> (i*w)) % modv;
            case (op)
                2'd0: begin r = (av + bv) % modv; fl = (av + bv) >= modv; end
                2'd1: begin r = (av + modv - bv) % modv; fl = av < bv; end
                2'd2: begin r = ((av + bv) >= modv) ? modv - 1 : av + bv; fl = (av + bv) >= modv; end
                default: begin r = (av < bv) ? 0 : av - bv; fl = av < bv; end
            endcase
            d = d | (64'(r) << (i*w));
            f[i] = fl;
        end
    endtask

    // One clock cycle on the 8x8 instance; called at posedge+1 with inputs already driven
    task automatic cycle_step(output bit acc);
        logic [63:0] ed;
        logic [63:0] ef;
        @(negedge clk);
        acc = in_valid && in_ready;
        chk("vec_count", 64'(vec_count), 64'(exp_cnt[15:0]));
        if (out_valid && !out_ready)
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (exp_dat_q.size() == 0) begin
            chk("spurious_valid", 64'(out_valid), 64'd0);
        end else if (out_valid) begin
            chk("out_data", out_data, exp_dat_q[0]);
            chk("out_ovf", 64'(out_ovf), exp_ovf_q[0]);
            if (out_ready) begin
                void'(exp_dat_q.pop_front());
                void'(exp_ovf_q.pop_front());
                exp_cnt++;
            end
        end
        if (acc) begin
            model(in_a, in_b, in_op, 8, 8, ed, ef);
            exp_dat_q.push_back(ed);
            exp_ovf_q.push_back(ef);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit          acc;
        int          sent;
        int          cyc;
        bit          found;
        logic [63:0] ed;
        logic [63:0] ef;

        n_chk = 0;
        n_fail = 0;
        exp_cnt = 0;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_a2 = '0; in_b2 = '0; in_op2 = 2'd0; out_ready2 = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_vec_count", 64'(vec_count), 64'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
        chk("rst_hold_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Basic add with latency check
        in_valid = 1'b1;
        in_a = 64'h1716151413121110;
        in_b = 64'h0101010101010101;
        in_op = 2'b00;
        out_ready = 1'b1;
        cycle_step(acc);
        chk("basic_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        cycle_step(acc);
        chk("lat_edge2_valid", 64'(out_valid), 64'd1);
        chk("basic_data", out_data, 64'h1817161514131211);
        chk("basic_ovf", 64'(out_ovf), 64'd0);
        cycle_step(acc);
        chk("basic_count", 64'(vec_count), 64'd1);

        // Carry at lane 0: wrapping then saturating add
        in_a = 64'h00000000000000FF;
        in_b = 64'h0000000000000002;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_op = (k == 0) ? 2'b00 : 2'b10;
            cycle_step(acc);
            in_valid = 1'b0;
            cycle_step(acc);
            chk("carry_lane0", 64'(out_data[7:0]), (k == 0) ? 64'h01 : 64'hFF);
            chk("carry_flag0", 64'(out_ovf[0]), 64'd1);
            cycle_step(acc);
        end

        // Borrow at lane 3: wrapping then saturating subtract
        in_a = 64'h2020202005202020;
        in_b = 64'h1010101007101010;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_op = (k == 0) ? 2'b01 : 2'b11;
            cycle_step(acc);
            in_valid = 1'b0;
            cycle_step(acc);
            chk("borrow_data", out_data, (k == 0) ? 64'h10101010FE101010 : 64'h1010101000101010);
            chk("borrow_ovf", 64'(out_ovf), 64'h08);
            cycle_step(acc);
        end

        // Four back-to-back vectors with a 5-cycle output stall starting at cycle 3
        sent = 0;
        exp_cnt = int'(vec_count);
        for (cyc = 0; cyc < 20; cyc++) begin
            in_valid = (sent < 4);
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_op = 2'($urandom_range(0, 3));
            out_ready = !(cyc >= 3 && cyc < 8);
            cycle_step(acc);
            if (acc) sent++;
        end
        chk("b2b_sent", 64'(sent), 64'd4);
        chk("b2b_drained", 64'(exp_dat_q.size()), 64'd0);

        // Random traffic with random backpressure
        for (cyc = 0; cyc < 1500; cyc++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            in_op = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 9) < 7);
            cycle_step(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle_step(acc);
        chk("rand_drained", 64'(exp_dat_q.size()), 64'd0);

        // Asynchronous reset mid-cycle with two vectors in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        cycle_step(acc);
        cycle_step(acc);
        in_valid = 1'b0;
        chk("inflight_valid", 64'(out_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_vec_count", 64'(vec_count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        exp_dat_q.delete();
        exp_ovf_q.delete();
        exp_cnt = 0;
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_release_ready", 64'(in_ready), 64'd1);
        repeat (8) cycle_step(acc);

        // 4x16 instance: lane 0 carry
        in_a2 = {$urandom, 16'($urandom), 16'hFFFF};
        in_b2 = {$urandom, 16'($urandom), 16'h0001};
        in_op2 = 2'b00;
        in_valid2 = 1'b1;
        out_ready2 = 1'b1;
        model(in_a2, in_b2, in_op2, 4, 16, ed, ef);
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("w16_valid", 64'(out_valid2), 64'd1);
        chk("w16_lane0", 64'(out_data2[15:0]), 64'h0000);
        chk("w16_ovf0", 64'(out_ovf2[0]), 64'd1);
        chk("w16_data", out_data2, ed);
        chk("w16_ovf", 64'(out_ovf2), ef);

        // Stream until the counter reaches its top, then one more transfer wraps it
        in_valid2 = 1'b1;
        found = 1'b0;
        for (cyc = 0; cyc < 70000 && !found; cyc++) begin
            @(negedge clk);
            if (vec_count2 == 16'hFFFF) found = 1'b1;
        end
        chk("wrap_reached", 64'(found), 64'd1);
        chk("wrap_stream_ready", 64'(in_ready2), 64'd1);
        @(negedge clk);
        chk("wrap_zero", 64'(vec_count2), 64'd0);
        in_valid2 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
